// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: hazard inputs from the datapath and forwarding/stall controls back to it
interface hazard_ctrl_if;
    logic [4:0]  regA1_D, regA2_D;
    logic [1:0]  Tuse_rs_D, Tuse_rt_D;
    logic [4:0]  regA1_E, regA2_E, regA2_M;
    logic [4:0]  regA3_E, regA3_M, regA3_W;
    logic [2:0]  Tnew_E, Tnew_M, Tnew_W;
    logic        md_start_D, md_div_D, md_use_D;
    logic [1:0]  regRD1Forward_D, regRD2Forward_D;
    logic [1:0]  regRD1Forward_E, regRD2Forward_E;
    logic        regRD2Forward_M;
    logic        stall;
    logic        md_busy;
    logic [31:0] stall_count;

    modport master (
        output regA1_D, regA2_D, Tuse_rs_D, Tuse_rt_D, regA1_E, regA2_E, regA2_M,
               regA3_E, regA3_M, regA3_W, Tnew_E, Tnew_M, Tnew_W,
               md_start_D, md_div_D, md_use_D,
        input  regRD1Forward_D, regRD2Forward_D, regRD1Forward_E, regRD2Forward_E,
               regRD2Forward_M, stall, md_busy, stall_count
    );

    modport slave (
        input  regA1_D, regA2_D, Tuse_rs_D, Tuse_rt_D, regA1_E, regA2_E, regA2_M,
               regA3_E, regA3_M, regA3_W, Tnew_E, Tnew_M, Tnew_W,
               md_start_D, md_div_D, md_use_D,
        output regRD1Forward_D, regRD2Forward_D, regRD1Forward_E, regRD2Forward_E,
               regRD2Forward_M, stall, md_busy, stall_count
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding selects, stall generation, MD busy window and stall counter
module hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic         clk,
    input logic         reset,
    hazard_ctrl_if.slave hz
);
    logic [3:0]  mdCnt;
    logic [31:0] stallCnt;
    logic [3:0]  remE, remM, remW;
    logic        hazRs, hazRt, mdStall, stallInt;

    function automatic logic [3:0] remLat(input logic [2:0] tNew, input logic [3:0] stage);
        return ({1'b0, tNew} > stage) ? {1'b0, tNew} - stage : 4'd0;
    endfunction

    function automatic logic hit(input logic [4:0] a, input logic [4:0] dst);
        return (a != 5'd0) && (dst == a);
    endfunction

    function automatic logic [1:0] selD(input logic [4:0] a, input logic [4:0] e, input logic [4:0] m,
                                        input logic [4:0] w, input logic [3:0] rE, input logic [3:0] rM,
                                        input logic [3:0] rW);
        return hit(a, e) ? ((rE == 4'd0) ? 2'd1 : 2'd0) :
               hit(a, m) ? ((rM == 4'd0) ? 2'd2 : 2'd0) :
               hit(a, w) ? ((rW == 4'd0) ? 2'd3 : 2'd0) : 2'd0;
    endfunction

    function automatic logic [1:0] selE(input logic [4:0] a, input logic [4:0] m, input logic [4:0] w,
                                        input logic [3:0] rM, input logic [3:0] rW);
        return hit(a, m) ? ((rM == 4'd0) ? 2'd1 : 2'd0) :
               hit(a, w) ? ((rW == 4'd0) ? 2'd2 : 2'd0) : 2'd0;
    endfunction

    // W is never consulted: anything in W is already valid or forwardable
    function automatic logic hazD(input logic [4:0] a, input logic [1:0] tUse, input logic [4:0] e,
                                  input logic [4:0] m, input logic [3:0] rE, input logic [3:0] rM);
        return (tUse == 2'd3) ? 1'b0 :
               hit(a, e) ? (rE > {2'b00, tUse}) :
               hit(a, m) ? (rM > {2'b00, tUse}) : 1'b0;
    endfunction

    // combinational forwarding selects and stall
    always_comb begin
        remE     = remLat(hz.Tnew_E, 4'd1);
        remM     = remLat(hz.Tnew_M, 4'd2);
        remW     = remLat(hz.Tnew_W, 4'd3);
        hazRs    = hazD(hz.regA1_D, hz.Tuse_rs_D, hz.regA3_E, hz.regA3_M, remE, remM);
        hazRt    = hazD(hz.regA2_D, hz.Tuse_rt_D, hz.regA3_E, hz.regA3_M, remE, remM);
        mdStall  = hz.md_use_D && (mdCnt != 4'd0);
        stallInt = hazRs || hazRt || mdStall;
        hz.regRD1Forward_D = selD(hz.regA1_D, hz.regA3_E, hz.regA3_M, hz.regA3_W, remE, remM, remW);
        hz.regRD2Forward_D = selD(hz.regA2_D, hz.regA3_E, hz.regA3_M, hz.regA3_W, remE, remM, remW);
        hz.regRD1Forward_E = selE(hz.regA1_E, hz.regA3_M, hz.regA3_W, remM, remW);
        hz.regRD2Forward_E = selE(hz.regA2_E, hz.regA3_M, hz.regA3_W, remM, remW);
        hz.regRD2Forward_M = hit(hz.regA2_M, hz.regA3_W) && (remW == 4'd0);
        hz.stall       = stallInt;
        hz.md_busy     = mdCnt != 4'd0;
        hz.stall_count = stallCnt;
    end

    // MD busy window: loads only when the start actually leaves D; +1 covers the E cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            mdCnt <= 4'd0;
        else if (hz.md_start_D && !stallInt)
            mdCnt <= hz.md_div_D ? 4'(DIV_CYCLES + 1) : 4'(MULT_CYCLES + 1);
        else if (mdCnt != 4'd0)
            mdCnt <= mdCnt - 4'd1;
    end

    // saturating stall-cycle counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stallCnt <= 32'd0;
        else if (stallInt && stallCnt != 32'hFFFF_FFFF)
            stallCnt <= stallCnt + 32'd1;
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven forwarding/stall vectors plus MD window and reset sequences
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    hazard_ctrl_if bus ();
    hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .hz(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] a1D, a2D;
        logic [1:0] tuRs, tuRt;
        logic [4:0] a1E, a2E, a2M, a3E, a3M, a3W;
        logic [2:0] tnE, tnM, tnW;
        logic [1:0] f1D, f2D, f1E, f2E;
        logic       f2M, st;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic applyVec(input vec_t v);
        bus.regA1_D = v.a1D; bus.regA2_D = v.a2D;
        bus.Tuse_rs_D = v.tuRs; bus.Tuse_rt_D = v.tuRt;
        bus.regA1_E = v.a1E; bus.regA2_E = v.a2E; bus.regA2_M = v.a2M;
        bus.regA3_E = v.a3E; bus.regA3_M = v.a3M; bus.regA3_W = v.a3W;
        bus.Tnew_E = v.tnE; bus.Tnew_M = v.tnM; bus.Tnew_W = v.tnW;
    endtask

    task automatic countStalls(input string name, input int exp);
        int n = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!bus.stall) break;
            n++;
            @(negedge clk);
        end
        chk(name, n, exp);
    endtask

    initial begin
        //          a1D a2D tRs tRt a1E a2E a2M a3E a3M a3W tnE tnM tnW  f1D f2D f1E f2E f2M st
        vecs[0]  = '{0,  0,  3,  3,  0,  0,  0,  0,  0,  0,  0,  0,  0,   0,  0,  0,  0,  0, 0};
        vecs[1]  = '{1,  0,  0,  3,  0,  0,  0,  1,  0,  0,  2,  0,  0,   0,  0,  0,  0,  0, 1};
        vecs[2]  = '{1,  0,  0,  3,  0,  0,  0,  0,  1,  0,  0,  2,  0,   2,  0,  0,  0,  0, 0};
        vecs[3]  = '{0,  2,  3,  1,  0,  0,  0,  2,  0,  0,  3,  0,  0,   0,  0,  0,  0,  0, 1};
        vecs[4]  = '{0,  2,  3,  1,  0,  0,  0,  0,  2,  0,  0,  3,  0,   0,  0,  0,  0,  0, 0};
        vecs[5]  = '{0,  0,  3,  3,  0,  2,  0,  0,  0,  2,  0,  0,  3,   0,  0,  0,  2,  0, 0};
        vecs[6]  = '{31, 0,  0,  3,  0,  0,  0, 31,  0,  0,  1,  0,  0,   1,  0,  0,  0,  0, 0};
        vecs[7]  = '{0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  2,  2,  2,   0,  0,  0,  0,  0, 0};
        vecs[8]  = '{5,  0,  0,  3,  5,  0,  5,  5,  5,  5,  1,  2,  3,   1,  0,  1,  0,  1, 0};
        vecs[9]  = '{6,  0,  2,  3,  0,  0,  0,  6,  6,  0,  3,  2,  0,   0,  0,  0,  0,  0, 0};
        vecs[10] = '{0,  7,  3,  0,  0,  7,  0,  0,  7,  0,  0,  3,  0,   0,  0,  0,  0,  0, 1};
        vecs[11] = '{8,  0,  3,  3,  0,  0,  0,  8,  0,  0,  3,  0,  0,   0,  0,  0,  0,  0, 0};
        vecs[12] = '{9,  0,  0,  3,  9,  0,  0,  0,  0,  9,  0,  0,  3,   3,  0,  2,  0,  0, 0};

        bus.md_start_D = 1'b0; bus.md_div_D = 1'b0; bus.md_use_D = 1'b0;
        applyVec(vecs[0]);
        #2;
        chk("reset_md_busy", bus.md_busy, 0);
        chk("reset_stall_count", bus.stall_count, 0);

        // combinational vectors applied while still in reset
        for (int i = 0; i < 13; i++) begin
            applyVec(vecs[i]);
            #1;
            chk($sformatf("v%0d_fwd1D", i), bus.regRD1Forward_D, vecs[i].f1D);
            chk($sformatf("v%0d_fwd2D", i), bus.regRD2Forward_D, vecs[i].f2D);
            chk($sformatf("v%0d_fwd1E", i), bus.regRD1Forward_E, vecs[i].f1E);
            chk($sformatf("v%0d_fwd2E", i), bus.regRD2Forward_E, vecs[i].f2E);
            chk($sformatf("v%0d_fwd2M", i), bus.regRD2Forward_M, vecs[i].f2M);
            chk($sformatf("v%0d_stall", i), bus.stall, vecs[i].st);
        end

        applyVec(vecs[0]);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_reset_count", bus.stall_count, 0);

        // div accepted, then mfhi held in D
        bus.md_start_D = 1'b1; bus.md_div_D = 1'b1; bus.md_use_D = 1'b1;
        #1 chk("div_start_stall", bus.stall, 0);
        @(negedge clk);
        bus.md_start_D = 1'b0;
        chk("div_busy", bus.md_busy, 1);
        countStalls("div_stall_cycles", 11);
        chk("div_busy_end", bus.md_busy, 0);
        chk("div_stall_count", bus.stall_count, 11);

        // mult blocked behind a div loads only once it leaves D
        bus.md_start_D = 1'b1; bus.md_div_D = 1'b1;
        @(negedge clk);
        bus.md_div_D = 1'b0;
        countStalls("blocked_mult_wait", 11);
        chk("blocked_mult_busy_before", bus.md_busy, 0);
        @(negedge clk);
        bus.md_start_D = 1'b0;
        countStalls("mult_stall_cycles", 6);
        chk("mult_stall_count", bus.stall_count, 28);

        // reset asserted mid-window clears immediately
        bus.md_start_D = 1'b1; bus.md_div_D = 1'b1;
        @(negedge clk);
        bus.md_start_D = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_busy", bus.md_busy, 1);
        #2 reset = 1'b0;
        #1;
        chk("async_reset_busy", bus.md_busy, 0);
        chk("async_reset_stall", bus.stall, 0);
        chk("async_reset_count", bus.stall_count, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("released_busy", bus.md_busy, 0);
        chk("released_stall", bus.stall, 0);
        chk("released_count", bus.stall_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Hazard and forwarding controller for the five-stage pipelined CPU. It sits beside the datapath and consumes the datapath's hazard outputs: source register addresses per stage, destination addresses, and pipelined `Tnew`. It produces the forwarding selects and the `stall` signal that the datapath consumes. It also models a multi-cycle mult/div unit's busy window and keeps a saturating count of stall cycles for performance debug.

## Interface
- `MULT_CYCLES`, 5: execution cycles of mult/multu after leaving E.
- `DIV_CYCLES`, 10: execution cycles of div/divu after leaving E.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `regA1_D`, `regA2_D`  in  5  rs/rt addresses of the instruction in D.
- `Tuse_rs_D`, `Tuse_rt_D`  in  2  cycles until the operand is consumed, counted from D: 0 = D, 1 = E, 2 = M, 3 = unused.
- `regA1_E`, `regA2_E`, `regA2_M`  in  5  source addresses held in E and M.
- `regA3_E`, `regA3_M`, `regA3_W`  in  5  destination addresses; 0 = no write.
- `Tnew_E`, `Tnew_M`, `Tnew_W`  in  3  stage at which the producer's result becomes valid: 1 = E, 2 = M, 3 = W.
- `md_start_D`  in  1  instruction in D is mult/multu/div/divu.
- `md_div_D`  in  1  qualifies `md_start_D`: 1 = div, 0 = mult.
- `md_use_D`  in  1  instruction in D accesses HI/LO or the MD unit (mfhi/mflo/mthi/mtlo/mult/div).
- `regRD1Forward_D`, `regRD2Forward_D`  out  2  D select: 0 RF, 1 EXBack, 2 MEMBack, 3 WBBack.
- `regRD1Forward_E`, `regRD2Forward_E`  out  2  E select: 0 pipelined value, 1 MEMBack, 2 WBBack.
- `regRD2Forward_M`  out  1  M store-data select: 0 pipelined value, 1 WBBack.
- `stall`  out  1  freezes PC and IF/ID; bubbles ID/EX.
- `md_busy`  out  1  MD counter nonzero.
- `stall_count`  out  32  number of stalled cycles since reset.

## Operation
- Remaining latency of a producer in stage s (E=1, M=2, W=3) is `rem_s = Tnew_s > s ? Tnew_s - s : 0`. This requires 4-bit arithmetic with no underflow.
- A stage matches source `a` when `a != 0` and `regA3_s == a`. Register 0 never matches.
- Forward selection, per source:
  - The nearest matching stage wins. D checks E, then M, then W. E checks M, then W. M checks W.
  - If the winning stage has `rem == 0`, select that stage's code.
  - If the winner has `rem != 0`, select 0.
  - If nothing matches, select 0.
- Data stall, per D source with `Tuse != 3`:
  - Take the nearest matching stage among E and M.
  - Raise `stall` when its `rem > Tuse`.
  - W never causes a data stall.
- MD stall: `stall` also rises when `md_use_D && md_busy`.
- `stall` is the OR of the rs data stall, the rt data stall, and the MD stall. It is purely combinational.
- MD counter `md_cnt`, 4 bits:
  - If `md_start_D && !stall` at an edge, load `DIV_CYCLES+1` when `md_div_D`, else `MULT_CYCLES+1`. The +1 covers the E cycle.
  - Else if `md_cnt != 0`, decrement.
  - Otherwise hold.
- `md_busy = (md_cnt != 0)`.
- `stall_count` increments on every edge where `stall == 1`. It saturates at 0xFFFFFFFF and never wraps.

## Timing
- Reset (`reset == 0`, asynchronous) clears `md_cnt` and `stall_count` to 0 immediately, so `md_busy` = 0.
- Forward selects and `stall` are combinational. During reset they follow their inputs with `md_busy` = 0; with all-zero inputs every output is 0.
- Selects and `stall` have zero-cycle latency from their inputs. `md_busy` and `stall_count` change only after a rising edge or on reset assertion.
- A mult accepted at edge t gives `md_busy` = 1 for cycles t+1 through t+6. A following `md_use_D` instruction leaves D at the first edge where `md_cnt == 0`.
- A blocked `md_start_D` (`stall` = 1) does not load the counter. It loads on the edge where it actually advances.
- `md_start_D` while `md_busy` with no stall cannot occur, because `md_start_D` implies `md_use_D`.
- Reset released mid-window: the counter restarts from 0, with no residual stall.

## Test plan
- E add writing $1 (`regA3_E`=1, `Tnew_E`=2), D `beq` using rs=1 with `Tuse_rs_D`=0 -> `stall`=1. Next cycle with `regA3_M`=1, `Tnew_M`=2 -> `stall`=0 and `regRD1Forward_D`=2.
- E `lw` writing $2 (`Tnew_E`=3), D `addu` rt=2 with `Tuse_rt_D`=1 -> `stall`=1. Same load in M -> `stall`=0 and `regRD2Forward_D`=0. On the next edge the instruction sits in E with `regRD2Forward_E`=2.
- E `jal` (`regA3_E`=31, `Tnew_E`=1), D `jr` with `Tuse_rs_D`=0 -> `stall`=0, `regRD1Forward_D`=1.
- Producers to $0 in E/M/W, all `Tnew`=2, D reads $0 -> all forward selects 0, `stall`=0.
- `div` accepted at edge t, then `mfhi` held in D -> `stall`=1 for 11 cycles, `md_busy` falls after edge t+11, and `stall_count` = 11.
- Assert `reset` mid-div window -> `md_busy`, `stall`, and `stall_count` go to 0 without waiting for a clock edge.
